// File: rtl/window_gen_if.sv
// window_gen_if: raster pixel stream in, convolution window plus strobes out.
interface window_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3
);
  localparam int KERNEL_SIZE = KERNEL_DIM * KERNEL_DIM;
  logic                  sof;
  logic                  pixel_valid;
  logic [DATA_WIDTH-1:0] pixel_in;
  logic [DATA_WIDTH-1:0] image [0:KERNEL_SIZE-1];
  logic                  en_convolve;
  logic                  frame_done;
  logic                  busy;
  modport master (output sof, pixel_valid, pixel_in, input image, en_convolve, frame_done, busy);
  modport slave (input sof, pixel_valid, pixel_in, output image, en_convolve, frame_done, busy);
endinterface

// File: rtl/window_gen.sv
// window_gen: line-buffered sliding-window generator for valid (unpadded) convolution.
module window_gen #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL_DIM = 3,
  localparam int KERNEL_SIZE = KERNEL_DIM * KERNEL_DIM
) (
  input logic        clk,
  input logic        rst,
  window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_DIM - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FILL  = RW'(KERNEL_DIM - 2);
  typedef enum logic {ST_FILL, ST_ACTIVE} state_t;
  state_t                state_q, state_d, st_e;
  logic [CW-1:0]         col_q, col_d, col_e;
  logic [RW-1:0]         row_q, row_d, row_e;
  logic [DATA_WIDTH-1:0] win_q [0:KERNEL_SIZE-1];
  logic [DATA_WIDTH-1:0] win_d [0:KERNEL_SIZE-1];
  logic [DATA_WIDTH-1:0] lb_q [0:KERNEL_DIM-2][0:IMG_WIDTH-1];
  logic                  en_q, en_d, done_q, done_d, busy_q, busy_d;
  logic                  last_col, last_row;
  // sof on an accepted pixel restarts the frame before this pixel is placed
  always_comb begin
    col_e    = bus.sof ? '0 : col_q;
    row_e    = bus.sof ? '0 : row_q;
    st_e     = bus.sof ? ST_FILL : state_q;
    last_col = col_e == COL_LAST;
    last_row = row_e == ROW_LAST;
    col_d    = col_q;
    row_d    = row_q;
    state_d  = state_q;
    win_d    = win_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    if (bus.pixel_valid) begin
      col_d   = last_col ? '0 : col_e + 1'b1;
      row_d   = last_col ? (last_row ? '0 : row_e + 1'b1) : row_e;
      state_d = st_e == ST_FILL ? ((last_col && row_e == ROW_FILL) ? ST_ACTIVE : ST_FILL)
                                : ((last_col && last_row) ? ST_FILL : ST_ACTIVE);
      for (int i = 0; i < KERNEL_SIZE - 1; i++) win_d[i] = win_q[i+1];
      for (int r = 0; r < KERNEL_DIM - 1; r++) win_d[r*KERNEL_DIM + KERNEL_DIM - 1] = lb_q[r][col_e];
      win_d[KERNEL_SIZE-1] = bus.pixel_in;
      en_d   = st_e == ST_ACTIVE && col_e >= COL_FIRST;
      done_d = en_d && last_col && last_row;
      busy_d = !done_d;
    end
  end
  // line buffers cascade upward: the last holds the previous row, the first the oldest
  always_ff @(posedge clk) begin
    if (bus.pixel_valid) begin
      for (int r = 0; r < KERNEL_DIM - 2; r++) lb_q[r][col_e] <= lb_q[r+1][col_e];
      lb_q[KERNEL_DIM-2][col_e] <= bus.pixel_in;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      col_q   <= '0;
      row_q   <= '0;
      for (int i = 0; i < KERNEL_SIZE; i++) win_q[i] <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.image       = win_q;
  assign bus.en_convolve = en_q;
  assign bus.frame_done  = done_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: directed checks of window_gen on a 5x5 image with a 3x3 kernel.
module tb_window_gen;
  localparam int W = 5, H = 5, K = 3, DW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  window_gen_if #(.DATA_WIDTH(DW), .KERNEL_DIM(K)) bus();
  window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .KERNEL_DIM(K)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    int after;
    int img [9];
    bit done;
  } vec_t;
  vec_t tab [9];
  int total = 0, bad = 0, n_en = 0, n_done = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_win(input string nm, input int base, input int t);
    for (int i = 0; i < 9; i++)
      chk($sformatf("%s_w%0d[%0d]", nm, t, i), 32'(bus.image[i]), 32'(base + tab[t].img[i]));
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] p);
    bus.pixel_valid = v;
    bus.sof = s;
    bus.pixel_in = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input string nm, input int base, input bit gaps, input bit use_sof, input int npix);
    int t = 0;
    bit strobed;
    for (int idx = 0; idx < npix; idx++) begin
      step(1'b1, use_sof && idx == 0, DW'(base + idx));
      n_en += int'(bus.en_convolve);
      n_done += int'(bus.frame_done);
      strobed = t < 9 && tab[t].after == idx;
      if (strobed) begin
        chk({nm, "_en"}, 32'(bus.en_convolve), 1);
        chk_win(nm, base, t);
        chk({nm, "_done"}, 32'(bus.frame_done), 32'(tab[t].done));
        chk({nm, "_busy"}, 32'(bus.busy), 32'(!tab[t].done));
        t++;
      end else begin
        chk({nm, "_noen"}, 32'(bus.en_convolve), 0);
        chk({nm, "_nodone"}, 32'(bus.frame_done), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 1);
      end
      if (gaps) begin
        step(1'b0, 1'b0, '0);
        chk({nm, "_gap_en"}, 32'(bus.en_convolve), 0);
        chk({nm, "_gap_done"}, 32'(bus.frame_done), 0);
        if (strobed) chk_win({nm, "_held"}, base, t - 1);
      end
    end
  endtask

  initial begin
    tab[0] = '{12, '{0, 1, 2, 5, 6, 7, 10, 11, 12}, 1'b0};
    tab[1] = '{13, '{1, 2, 3, 6, 7, 8, 11, 12, 13}, 1'b0};
    tab[2] = '{14, '{2, 3, 4, 7, 8, 9, 12, 13, 14}, 1'b0};
    tab[3] = '{17, '{5, 6, 7, 10, 11, 12, 15, 16, 17}, 1'b0};
    tab[4] = '{18, '{6, 7, 8, 11, 12, 13, 16, 17, 18}, 1'b0};
    tab[5] = '{19, '{7, 8, 9, 12, 13, 14, 17, 18, 19}, 1'b0};
    tab[6] = '{22, '{10, 11, 12, 15, 16, 17, 20, 21, 22}, 1'b0};
    tab[7] = '{23, '{11, 12, 13, 16, 17, 18, 21, 22, 23}, 1'b0};
    tab[8] = '{24, '{12, 13, 14, 17, 18, 19, 22, 23, 24}, 1'b1};
    bus.sof = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(bus.en_convolve), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 9; i++) chk($sformatf("rst_img[%0d]", i), 32'(bus.image[i]), 0);
    rst = 1'b1;
    @(negedge clk);
    run_frame("cont", 0, 1'b0, 1'b1, 25);
    run_frame("gaps", 0, 1'b1, 1'b1, 25);
    n_en = 0;
    n_done = 0;
    run_frame("b2b_a", 0, 1'b0, 1'b1, 25);
    run_frame("b2b_b", 100, 1'b0, 1'b0, 25);
    chk("b2b_strobes", 32'(n_en), 18);
    chk("b2b_dones", 32'(n_done), 2);
    n_done = 0;
    run_frame("abort8", 50, 1'b0, 1'b1, 9);
    run_frame("abort14", 60, 1'b0, 1'b1, 14);
    chk("abort_dones", 32'(n_done), 0);
    run_frame("fresh", 0, 1'b0, 1'b1, 25);
    run_frame("pre_rst", 0, 1'b0, 1'b1, 13);
    bus.pixel_valid = 1'b1;
    bus.pixel_in = 8'd13;
    #2 rst = 1'b0;
    #1;
    chk("async_en", 32'(bus.en_convolve), 0);
    chk("async_busy", 32'(bus.busy), 0);
    chk("async_done", 32'(bus.frame_done), 0);
    for (int i = 0; i < 9; i++) chk($sformatf("async_img[%0d]", i), 32'(bus.image[i]), 0);
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame("post_rst", 0, 1'b0, 1'b0, 25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Sliding-window generator that feeds the `convolve` engine.
- Accepts a raster-order pixel stream (row-major, one pixel per valid cycle) and buffers KERNEL_DIM-1 previous image rows in line buffers.
- Emits every KERNEL_DIM x KERNEL_DIM window of a "valid" (unpadded) convolution, with a one-cycle enable strobe matching the `convolve` input interface (image array plus en_convolve).

Parameters:
- IMG_WIDTH, 28, pixels per image row (>= KERNEL_DIM)
- IMG_HEIGHT, 28, rows per frame (>= KERNEL_DIM)
- DATA_WIDTH, 8, pixel width in bits
- KERNEL_DIM, 3, window edge length; window holds KERNEL_DIM*KERNEL_DIM pixels
- KERNEL_SIZE, KERNEL_DIM*KERNEL_DIM, derived; do not override

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- sof  input  1  start of frame; qualified by pixel_valid; marks pixel_in as position (0,0)
- pixel_valid  input  1  pixel_in is valid this cycle
- pixel_in  input  DATA_WIDTH  raster-order pixel
- image  output  DATA_WIDTH x [0:KERNEL_SIZE-1]  window, row-major; index 0 = top-left (oldest row, oldest column); index KERNEL_SIZE-1 = newest pixel
- en_convolve  output  1  one-cycle strobe: image holds a complete window
- frame_done  output  1  one-cycle pulse coincident with the last en_convolve of a frame
- busy  output  1  high from the first accepted pixel of a frame until frame_done

Behaviour:
- Reset (rst low, async):
  - col/row counters cleared to 0; FSM to ST_FILL.
  - image all 0; en_convolve, frame_done and busy all 0.
  - Line-buffer contents need no reset.
- Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1, both advancing only on accepted pixels (pixel_valid=1).
  - col wraps to 0 and increments row.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 and the FSM returns to ST_FILL.
- Storage:
  - KERNEL_DIM-1 line buffers, each IMG_WIDTH deep, written at address col.
  - A KERNEL_DIM x KERNEL_DIM shift-register window; per accepted pixel each window row shifts left by one.
  - Newest column is loaded from {line buffers at col, pixel_in}; the line buffers cascade the pixel upward.
- FSM:
  - ST_FILL: row < KERNEL_DIM-1; no windows emitted. Transitions to ST_ACTIVE on the accepted pixel that makes row = KERNEL_DIM-1, col = 0.
  - ST_ACTIVE: emit a window on each accepted pixel with col >= KERNEL_DIM-1. Transitions to ST_FILL after the last pixel of the frame.
- Latency: en_convolve and image are registered outputs, asserted the cycle after the pixel completing the window is accepted.
- Output count: exactly (IMG_WIDTH-KERNEL_DIM+1)*(IMG_HEIGHT-KERNEL_DIM+1) strobes per frame. Windows never span a row boundary; there is no strobe at col < KERNEL_DIM-1.
- pixel_valid low:
  - No state change; en_convolve is 0 the next cycle.
  - image holds its last value.
  - Gaps of any length are legal, including mid-row.
- sof:
  - sof with pixel_valid forces this pixel to (0,0): counters reset before the write, FSM to ST_FILL, and any partial frame is abandoned without frame_done.
  - sof without pixel_valid is ignored.
- busy: set on any accepted pixel; cleared the cycle frame_done asserts.
- frame_done: asserted with the en_convolve for window (row=IMG_HEIGHT-1, col=IMG_WIDTH-1).
- Reset mid-frame: all outputs drop immediately (async). The next accepted pixel is treated as (0,0) regardless of sof.
- No backpressure: the downstream `convolve` accepts one window per cycle.

Test Plan:
- 5x5 image, KERNEL_DIM=3, pixel = row*5+col, pixel_valid continuous:
  - first strobe one cycle after pixel 12, image = {0,1,2,5,6,7,10,11,12};
  - exactly 9 strobes;
  - last image = {12,13,14,17,18,19,22,23,24} with frame_done=1.
- Same frame with pixel_valid toggling 1/0 every cycle -> identical 9 windows in order; en_convolve never high two consecutive cycles; image held during gaps.
- Row boundary: after the window ending at pixel 14 -> no strobe for pixels 15 and 16; next window {5,6,7,10,11,12,15,16,17} after pixel 17.
- Two back-to-back 5x5 frames, second with pixel = 100+index -> 18 strobes and 2 frame_done pulses; second frame's first window = {100,101,102,105,106,107,110,111,112}; no window mixes frames.
- sof with pixel_valid asserted at pixel 8 of frame 1, then a full fresh frame -> no frame_done for the aborted frame; 9 correct windows afterwards.
- rst pulsed low at pixel 13 -> outputs 0 immediately (async); next full frame produces 9 correct windows with frame_done.
